riscv_pmacfg_regs: RTL and testbench
====================================

// Module: riscv_pmacfg_regs
// PURPOSE
//  Writer side of the PMA checker's configuration interface. Holds PMA_CNT pmacfg_t/address entries.
//  Software writes shadow copies over a simple req/ack config port.
//  A commit FSM drains the memory pipeline, then copies shadow to active in one cycle.
//  Active copies drive pma_cfg_o/pma_adr_o into the instruction- and data-side PMA checkers.
// PARAMETERS
//  XLEN     32                     data/address register width
//  PLEN     XLEN==32 ? 34 : 56     physical address width; addr regs keep bits [PLEN-3:0]
//  PMA_CNT  16                     number of PMA entries
//  RST_CFG  '{a:NAPOT,mem_type:MAIN,r,w,x:1,others 0}  entry 0 reset cfg; entries 1..N-1 reset a=OFF, rest 0
//  RST_ADR  {XLEN{1'b1}}>>1        entry 0 reset address; entries 1..N-1 reset 0
// PORTS
//  rst_ni       in   1                  synchronous reset, active low
//  clk_i        in   1                  clock, all state on rising edge
//  cfg_req_i    in   1                  config access request, held until cfg_ack_o
//  cfg_we_i     in   1                  1=write, 0=read
//  cfg_adr_i    in   $clog2(2*PMA_CNT)+1  word index: 2k=cfg[k], 2k+1=adr[k], 2*PMA_CNT=COMMIT
//  cfg_d_i      in   XLEN               write data
//  cfg_q_o      out  XLEN               read data, valid with cfg_ack_o
//  cfg_ack_o    out  1                  one-cycle access-complete pulse
//  cfg_err_o    out  1                  with ack: index > 2*PMA_CNT
//  drain_req_o  out  1                  request memory pipeline to go idle
//  drain_ack_i  in   1                  pipeline idle, no outstanding BIU transfers
//  pma_cfg_o    out  pmacfg_t[PMA_CNT]  active configuration to checkers
//  pma_adr_o    out  XLEN[PMA_CNT]      active addresses to checkers
//  busy_o       out  1                  commit in progress
//  updated_o    out  1                  one-cycle pulse, active set replaced
// BEHAVIOUR
//  Reset: shadow=active=RST values, FSM=IDLE, dirty=0, all outputs 0 except pma_cfg_o/pma_adr_o=RST.
//  Reset mid-commit aborts; active copy returns to RST, not shadow.
//  Config port:
//   - req accepted only in IDLE; ack 1 cycle after acceptance, q/err registered.
//   - In WAIT_DRAIN/APPLY, ack stays 0 and req stalls; no back-to-back ack for the same held req.
//  Cfg word packing (pma_pkg constants):
//   - [1:0]a [3:2]mem_type [5:4]amo_type [6]r [7]w [8]x [9]c [10]cc [11]ri [12]wi [13]m [15]L
//   - other bits write-ignored, read 0.
//  Addr word: bits >= PLEN-2 write-ignored, read 0.
//  Reads return shadow values. Any accepted write to cfg/adr sets dirty.
//  COMMIT read returns {.., dirty, busy} in bits [1:0]; write of any data starts commit.
//  FSM:
//   - IDLE -> WAIT_DRAIN on COMMIT write with dirty=1 (drain_req_o=1 next cycle, busy_o=1).
//   - COMMIT write with dirty=0: ack only, no drain, no updated_o.
//   - WAIT_DRAIN -> APPLY when drain_ack_i=1 (sampled; may already be 1 on entry, min 1 cycle).
//   - APPLY (1 cycle): active<=shadow, dirty<=0, drain_req_o<=0, then -> IDLE.
//     The COMMIT ack and updated_o pulse together in the cycle after APPLY.
//  Active outputs change only via APPLY or reset; checkers never see partial updates.
// CONFIGURATION
//  PMA_LOCK_EN defined:
//   - L bit stored. Writes to cfg[k]/adr[k] with L=1 are silently ignored (ack, err=0, dirty unchanged).
//   - adr[k] also locked when cfg[k+1].L=1 and cfg[k+1].a==TOR.
//   - L clears only on reset.
//  PMA_LOCK_EN undefined: L reads 0, no locking logic synthesised.
// STRUCTURE
//  riscv_pma_pkg: pmacfg_t, field-offset constants, pmacfg_pack()/pmacfg_unpack(), COMMIT index function.
//  One sub-module riscv_pmacfg_entry (shadow+active regs, lock, WARL masking) generated PMA_CNT times.
//  Top holds the port decode, read mux and commit FSM.
// TESTING
//  Reset -> pma_cfg_o[0].a=NAPOT, r/w/x=1, pma_adr_o[0]=32'h7FFF_FFFF; entries 1..15 a=OFF; ack=0, busy=0.
//  Write cfg[3]=16'h20C5, read back -> q=32'h0000_20C5, pma_cfg_o[3] unchanged until commit.
//  Write COMMIT, hold drain_ack_i=0 for 5 cycles -> busy=1, drain_req=1, no ack.
//   Then drain_ack_i=1 -> APPLY, then ack+updated_o pulse, pma_cfg_o[3].a=NA4 (2'b01), busy=0.
//  Read adr index 2*PMA_CNT+1 -> ack with err=1, q=0. Write adr[2]=32'hFFFF_FFFF (PLEN=34) -> reads 32'hFFFF_FFFF.
//  Commit with dirty=0 -> ack 1 cycle later, drain_req stays 0, no updated_o.
//  PMA_LOCK_EN: cfg[5] L=1, a=TOR, committed; write adr[4] -> ack, value unchanged, dirty stays 0.
//   Repeat after rst_ni low 1 cycle -> write takes.

Source files
------------

// File: rtl/riscv_pma_pkg.sv
// riscv_pma_pkg: shared types and helpers for the PMA configuration registers.
//   pmacfg_t      one PMA entry configuration (enums for address match and memory type)
//   CFG_*         bit offsets of each field inside a software-visible cfg word
//   pmacfg_pack / pmacfg_unpack   struct <-> cfg word conversion (unused bits read 0)
//   commit_idx    word index of the COMMIT register for a given entry count
//   commit_state_t  commit FSM states
package riscv_pma_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    NA4   = 2'b01,
    TOR   = 2'b10,
    NAPOT = 2'b11
  } pma_a_t;

  typedef enum logic [1:0] {
    MEM_EMPTY = 2'b00,
    MAIN      = 2'b01,
    IO        = 2'b10,
    TCM       = 2'b11
  } pma_mem_t;

  typedef struct packed {
    logic       l;
    logic       m;
    logic       wi;
    logic       ri;
    logic       cc;
    logic       c;
    logic       x;
    logic       w;
    logic       r;
    logic [1:0] amo_type;
    pma_mem_t   mem_type;
    pma_a_t     a;
  } pmacfg_t;

  localparam int CFG_A   = 0;
  localparam int CFG_MT  = 2;
  localparam int CFG_AMO = 4;
  localparam int CFG_R   = 6;
  localparam int CFG_W   = 7;
  localparam int CFG_X   = 8;
  localparam int CFG_C   = 9;
  localparam int CFG_CC  = 10;
  localparam int CFG_RI  = 11;
  localparam int CFG_WI  = 12;
  localparam int CFG_M   = 13;
  localparam int CFG_L   = 15;

  localparam pmacfg_t PMACFG_OFF = '{
    l: 1'b0, m: 1'b0, wi: 1'b0, ri: 1'b0, cc: 1'b0, c: 1'b0,
    x: 1'b0, w: 1'b0, r: 1'b0, amo_type: 2'b00, mem_type: MEM_EMPTY, a: OFF
  };

  localparam pmacfg_t PMACFG_RST0 = '{
    l: 1'b0, m: 1'b0, wi: 1'b0, ri: 1'b0, cc: 1'b0, c: 1'b0,
    x: 1'b1, w: 1'b1, r: 1'b1, amo_type: 2'b00, mem_type: MAIN, a: NAPOT
  };

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_WAIT_DRAIN = 2'b01,
    ST_APPLY      = 2'b10
  } commit_state_t;

  function automatic logic [15:0] pmacfg_pack(input pmacfg_t c);
    logic [15:0] v;
    v               = '0;
    v[CFG_A +: 2]   = c.a;
    v[CFG_MT +: 2]  = c.mem_type;
    v[CFG_AMO +: 2] = c.amo_type;
    v[CFG_R]        = c.r;
    v[CFG_W]        = c.w;
    v[CFG_X]        = c.x;
    v[CFG_C]        = c.c;
    v[CFG_CC]       = c.cc;
    v[CFG_RI]       = c.ri;
    v[CFG_WI]       = c.wi;
    v[CFG_M]        = c.m;
    v[CFG_L]        = c.l;
    return v;
  endfunction

  function automatic pmacfg_t pmacfg_unpack(input logic [15:0] v);
    pmacfg_t c;
    c.a        = pma_a_t'(v[CFG_A +: 2]);
    c.mem_type = pma_mem_t'(v[CFG_MT +: 2]);
    c.amo_type = v[CFG_AMO +: 2];
    c.r        = v[CFG_R];
    c.w        = v[CFG_W];
    c.x        = v[CFG_X];
    c.c        = v[CFG_C];
    c.cc       = v[CFG_CC];
    c.ri       = v[CFG_RI];
    c.wi       = v[CFG_WI];
    c.m        = v[CFG_M];
    c.l        = v[CFG_L];
    return c;
  endfunction

  function automatic int commit_idx(input int cnt);
    return 2 * cnt;
  endfunction

endpackage

// File: rtl/riscv_pmacfg_regs_if.sv
// riscv_pmacfg_regs_if: software config port (req/ack word access).
//   master drives req/we/adr/d and holds req until ack; slave returns q/err with a one-cycle ack.
//   Ports: req, we, adr[AW], d[XLEN] (master->slave); q[XLEN], ack, err (slave->master).
interface riscv_pmacfg_regs_if #(
  parameter int XLEN = 32,
  parameter int AW   = 6
);
  logic            req;
  logic            we;
  logic [AW-1:0]   adr;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] q;
  logic            ack;
  logic            err;

  modport master (output req, we, adr, d, input q, ack, err);
  modport slave  (input req, we, adr, d, output q, ack, err);
endinterface

// File: rtl/riscv_pmacfg_entry.sv
// riscv_pmacfg_entry: one PMA entry, shadow (software) and active (checker) copies.
//   Latency: shadow writes land next cycle; active copy loads from shadow on apply_i.
//   Backpressure: none; locked writes are dropped and reported through cfg_lock_o/adr_lock_o.
//   Ports: clk_i, rst_ni, cfg_we_i/adr_we_i + wdat_i (shadow writes), apply_i,
//          next_tor_lock_i (entry k+1 is locked TOR), sh_*_o (shadow), act_*_o (active), *_lock_o.
//   Macro PMA_LOCK_EN: stores L and enables write locking; otherwise L reads 0.
module riscv_pmacfg_entry
  import riscv_pma_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              PLEN    = 34,
  parameter pmacfg_t         RST_CFG = PMACFG_OFF,
  parameter logic [XLEN-1:0] RST_ADR = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_we_i,
  input  logic            adr_we_i,
  input  logic [XLEN-1:0] wdat_i,
  input  logic            apply_i,
  input  logic            next_tor_lock_i,
  output pmacfg_t         sh_cfg_o,
  output logic [XLEN-1:0] sh_adr_o,
  output pmacfg_t         act_cfg_o,
  output logic [XLEN-1:0] act_adr_o,
  output logic            cfg_lock_o,
  output logic            adr_lock_o
);

  // Address registers hold physical address bits [PLEN-1:2], i.e. word bits [PLEN-3:0].
  localparam int KEEP = (PLEN - 2 < XLEN) ? (PLEN - 2) : XLEN;

  function automatic logic [XLEN-1:0] adr_mask();
    logic [XLEN-1:0] m;
    for (int i = 0; i < XLEN; i++) m[i] = (i < KEEP);
    return m;
  endfunction

  localparam logic [XLEN-1:0] ADR_MASK = adr_mask();

  pmacfg_t         sh_cfg_q, act_cfg_q, sh_cfg_d;
  logic [XLEN-1:0] sh_adr_q, act_adr_q;

`ifdef PMA_LOCK_EN
  // A TOR match for entry k+1 uses adr[k] as its base, so that lock reaches down one entry.
  assign cfg_lock_o = sh_cfg_q.l;
  assign adr_lock_o = sh_cfg_q.l | next_tor_lock_i;
  always_comb sh_cfg_d = pmacfg_unpack(wdat_i[15:0]);
`else
  logic unused_tor_lock;
  assign unused_tor_lock = next_tor_lock_i;
  assign cfg_lock_o      = 1'b0;
  assign adr_lock_o      = 1'b0;
  always_comb begin
    sh_cfg_d   = pmacfg_unpack(wdat_i[15:0]);
    sh_cfg_d.l = 1'b0;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_cfg_q  <= RST_CFG;
      sh_adr_q  <= RST_ADR & ADR_MASK;
      act_cfg_q <= RST_CFG;
      act_adr_q <= RST_ADR & ADR_MASK;
    end else begin
      if (cfg_we_i && !cfg_lock_o) sh_cfg_q <= sh_cfg_d;
      if (adr_we_i && !adr_lock_o) sh_adr_q <= wdat_i & ADR_MASK;
      if (apply_i) begin
        act_cfg_q <= sh_cfg_q;
        act_adr_q <= sh_adr_q;
      end
    end
  end

  assign sh_cfg_o  = sh_cfg_q;
  assign sh_adr_o  = sh_adr_q;
  assign act_cfg_o = act_cfg_q;
  assign act_adr_o = act_adr_q;

endmodule

// File: rtl/riscv_pmacfg_regs.sv
// riscv_pmacfg_regs: PMA configuration writer; shadow regs over a req/ack port, committed atomically.
//   Latency: accesses ack 1 cycle after acceptance; dirty COMMIT acks 1 cycle after APPLY.
//   Backpressure: requests stall (no ack) while a commit drains the memory pipeline.
//   Ports: rst_ni (sync, active low), clk_i, cfg (config slave port), drain_req_o/drain_ack_i
//          (pipeline drain handshake), pma_cfg_o/pma_adr_o (active set), busy_o, updated_o.
//   Macro PMA_LOCK_EN: enables per-entry L-bit write locking.
module riscv_pmacfg_regs
  import riscv_pma_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              PLEN    = (XLEN == 32) ? 34 : 56,
  parameter int              PMA_CNT = 16,
  parameter pmacfg_t         RST_CFG = PMACFG_RST0,
  parameter logic [XLEN-1:0] RST_ADR = {XLEN{1'b1}} >> 1
) (
  input  logic                 rst_ni,
  input  logic                 clk_i,
  riscv_pmacfg_regs_if.slave   cfg,
  output logic                 drain_req_o,
  input  logic                 drain_ack_i,
  output pmacfg_t              pma_cfg_o [PMA_CNT],
  output logic [XLEN-1:0]      pma_adr_o [PMA_CNT],
  output logic                 busy_o,
  output logic                 updated_o
);

  localparam int            AW         = $clog2(2 * PMA_CNT) + 1;
  localparam int            IW         = $clog2(PMA_CNT);
  localparam logic [AW-1:0] COMMIT_IDX = AW'(commit_idx(PMA_CNT));

  commit_state_t   state_q;
  logic            ack_q, err_q, dirty_q, drain_req_q, busy_q, upd_q;
  logic [XLEN-1:0] q_q;

  pmacfg_t         sh_cfg [PMA_CNT];
  logic [XLEN-1:0] sh_adr [PMA_CNT];
  logic [PMA_CNT-1:0] cfg_we, adr_we, cfg_lck, adr_lck, tor_lk;

  logic [IW-1:0]   ent;
  logic            idx_commit, idx_err, idx_entry;
  logic            accept, acc_wr, wr_hit, apply;
  logic [XLEN-1:0] rd_dat;

  assign ent        = cfg.adr[IW:1];
  assign idx_commit = (cfg.adr == COMMIT_IDX);
  assign idx_err    = (cfg.adr > COMMIT_IDX);
  assign idx_entry  = (cfg.adr < COMMIT_IDX);

  // ack_q blocks re-acceptance of the same held request in the ack cycle.
  assign accept = (state_q == ST_IDLE) && cfg.req && !ack_q;
  assign acc_wr = accept && cfg.we;
  assign apply  = (state_q == ST_APPLY);

  // Only writes that actually change shadow state mark the set dirty.
  assign wr_hit = acc_wr && idx_entry && !(cfg.adr[0] ? adr_lck[ent] : cfg_lck[ent]);

  for (genvar k = 0; k < PMA_CNT; k++) begin : g_ent
    assign cfg_we[k] = acc_wr && (cfg.adr == AW'(2 * k));
    assign adr_we[k] = acc_wr && (cfg.adr == AW'(2 * k + 1));

    if (k < PMA_CNT - 1) begin : g_tor
      assign tor_lk[k] = sh_cfg[k+1].l && (sh_cfg[k+1].a == TOR);
    end else begin : g_last
      assign tor_lk[k] = 1'b0;
    end

    riscv_pmacfg_entry #(
      .XLEN    (XLEN),
      .PLEN    (PLEN),
      .RST_CFG ((k == 0) ? RST_CFG : PMACFG_OFF),
      .RST_ADR ((k == 0) ? RST_ADR : {XLEN{1'b0}})
    ) u_entry (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .cfg_we_i        (cfg_we[k]),
      .adr_we_i        (adr_we[k]),
      .wdat_i          (cfg.d),
      .apply_i         (apply),
      .next_tor_lock_i (tor_lk[k]),
      .sh_cfg_o        (sh_cfg[k]),
      .sh_adr_o        (sh_adr[k]),
      .act_cfg_o       (pma_cfg_o[k]),
      .act_adr_o       (pma_adr_o[k]),
      .cfg_lock_o      (cfg_lck[k]),
      .adr_lock_o      (adr_lck[k])
    );
  end

  // Reads always return the shadow copy.
  always_comb begin
    rd_dat = '0;
    if (idx_commit)
      rd_dat = {{(XLEN-2){1'b0}}, dirty_q, busy_q};
    else if (idx_entry)
      rd_dat = cfg.adr[0] ? sh_adr[ent] : {{(XLEN-16){1'b0}}, pmacfg_pack(sh_cfg[ent])};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      q_q         <= '0;
      dirty_q     <= 1'b0;
      drain_req_q <= 1'b0;
      busy_q      <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      upd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (idx_commit && cfg.we && dirty_q) begin
              // Ack for this COMMIT is deferred until the active set is replaced.
              state_q     <= ST_WAIT_DRAIN;
              drain_req_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              ack_q <= 1'b1;
              err_q <= idx_err;
              q_q   <= cfg.we ? '0 : rd_dat;
              if (wr_hit) dirty_q <= 1'b1;
            end
          end
        end
        ST_WAIT_DRAIN: begin
          if (drain_ack_i) state_q <= ST_APPLY;
        end
        ST_APPLY: begin
          state_q     <= ST_IDLE;
          dirty_q     <= 1'b0;
          drain_req_q <= 1'b0;
          busy_q      <= 1'b0;
          ack_q       <= 1'b1;
          upd_q       <= 1'b1;
          err_q       <= 1'b0;
          q_q         <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg.ack     = ack_q;
  assign cfg.err     = err_q;
  assign cfg.q       = q_q;
  assign drain_req_o = drain_req_q;
  assign busy_o      = busy_q;
  assign updated_o   = upd_q;

endmodule

// File: tb/tb_riscv_pmacfg_regs.sv
module tb_riscv_pmacfg_regs;
  import riscv_pma_pkg::*;

  localparam int XLEN    = 32;
  localparam int PMA_CNT = 16;
  localparam int AW      = 6;
  localparam logic [AW-1:0] COMMIT = 6'd32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drain_ack = 1'b0;
  logic drain_req, busy, updated;
  pmacfg_t     pma_cfg [PMA_CNT];
  logic [31:0] pma_adr [PMA_CNT];

  int compared = 0;
  int mismatched = 0;

  riscv_pmacfg_regs_if #(.XLEN(XLEN), .AW(AW)) cfg_if ();

  riscv_pmacfg_regs #(.XLEN(XLEN), .PMA_CNT(PMA_CNT)) dut (
    .rst_ni      (rst_n),
    .clk_i       (clk),
    .cfg         (cfg_if),
    .drain_req_o (drain_req),
    .drain_ack_i (drain_ack),
    .pma_cfg_o   (pma_cfg),
    .pma_adr_o   (pma_adr),
    .busy_o      (busy),
    .updated_o   (updated)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    cfg_if.req = 1'b0; cfg_if.we = 1'b0; cfg_if.adr = '0; cfg_if.d = '0;
    drain_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Stimulus driver: one held request, returns ack data and cycles to ack (100 = no ack).
  task automatic access(input logic we, input logic [AW-1:0] adr, input logic [31:0] d,
                        output logic [31:0] q, output logic err, output int cyc,
                        output logic upd_seen, output logic drain_seen);
    @(posedge clk); #1;
    cfg_if.req = 1'b1; cfg_if.we = we; cfg_if.adr = adr; cfg_if.d = d;
    cyc = 0; q = 'x; err = 1'bx; upd_seen = 1'b0; drain_seen = 1'b0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (drain_req) drain_seen = 1'b1;
      if (updated) upd_seen = 1'b1;
      if (cfg_if.ack) begin
        q = cfg_if.q; err = cfg_if.err;
        break;
      end
    end
    cfg_if.req = 1'b0;
  endtask

  task automatic test_reset();
    compared++; if (pma_cfg[0].a !== NAPOT) begin mismatched++; $display("FAIL rst_cfg0_a: got %b, expected %b", pma_cfg[0].a, NAPOT); end
    compared++; if (pma_cfg[0].mem_type !== MAIN) begin mismatched++; $display("FAIL rst_cfg0_mt: got %b, expected %b", pma_cfg[0].mem_type, MAIN); end
    compared++; if ({pma_cfg[0].r, pma_cfg[0].w, pma_cfg[0].x} !== 3'b111) begin mismatched++; $display("FAIL rst_cfg0_rwx: got %b, expected 111", {pma_cfg[0].r, pma_cfg[0].w, pma_cfg[0].x}); end
    compared++; if ({pma_cfg[0].c, pma_cfg[0].cc, pma_cfg[0].ri, pma_cfg[0].wi, pma_cfg[0].m, pma_cfg[0].l, pma_cfg[0].amo_type} !== 8'h00) begin mismatched++; $display("FAIL rst_cfg0_other: nonzero fields"); end
    compared++; if (pma_adr[0] !== 32'h7FFF_FFFF) begin mismatched++; $display("FAIL rst_adr0: got %h, expected 7fffffff", pma_adr[0]); end
    for (int k = 1; k < PMA_CNT; k++) begin
      compared++; if (pma_cfg[k] !== '0) begin mismatched++; $display("FAIL rst_cfg%0d: got %h, expected 0 (a=OFF)", k, pma_cfg[k]); end
      compared++; if (pma_adr[k] !== 32'h0) begin mismatched++; $display("FAIL rst_adr%0d: got %h, expected 0", k, pma_adr[k]); end
    end
    compared++; if ({cfg_if.ack, cfg_if.err, busy, drain_req, updated} !== 5'b0) begin mismatched++; $display("FAIL rst_flags: got %b, expected 00000", {cfg_if.ack, cfg_if.err, busy, drain_req, updated}); end
    compared++; if (cfg_if.q !== 32'h0) begin mismatched++; $display("FAIL rst_q: got %h, expected 0", cfg_if.q); end
  endtask

  task automatic test_rw_shadow();
    logic [31:0] q; logic e, us, ds; int c;
    access(1'b1, 6'd6, 32'h0000_20C5, q, e, c, us, ds);
    compared++; if (c !== 1) begin mismatched++; $display("FAIL wr_cfg3_latency: got %0d, expected 1", c); end
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL wr_cfg3_err: got %b, expected 0", e); end
    access(1'b0, 6'd6, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0000_20C5) begin mismatched++; $display("FAIL rd_cfg3: got %h, expected 000020c5", q); end
    compared++; if (pma_cfg[3] !== '0) begin mismatched++; $display("FAIL cfg3_active_early: got %h, expected 0", pma_cfg[3]); end
    access(1'b0, COMMIT, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h2) begin mismatched++; $display("FAIL rd_commit_dirty: got %h, expected 2", q); end
  endtask

  task automatic test_commit_drain();
    logic [31:0] q; logic e, us, ds; int c;
    drain_ack = 1'b0;
    @(posedge clk); #1;
    cfg_if.req = 1'b1; cfg_if.we = 1'b1; cfg_if.adr = COMMIT; cfg_if.d = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      compared++; if ({busy, drain_req, cfg_if.ack} !== 3'b110) begin mismatched++; $display("FAIL drain_wait%0d busy/drain/ack: got %b, expected 110", i, {busy, drain_req, cfg_if.ack}); end
    end
    compared++; if (pma_cfg[3].a !== OFF) begin mismatched++; $display("FAIL cfg3_during_drain: got %b, expected 00", pma_cfg[3].a); end
    drain_ack = 1'b1;
    @(posedge clk); #1;
    compared++; if ({cfg_if.ack, updated} !== 2'b00) begin mismatched++; $display("FAIL apply_cycle ack/upd: got %b, expected 00", {cfg_if.ack, updated}); end
    @(posedge clk); #1;
    compared++; if ({cfg_if.ack, updated, busy, drain_req} !== 4'b1100) begin mismatched++; $display("FAIL commit_done ack/upd/busy/drain: got %b, expected 1100", {cfg_if.ack, updated, busy, drain_req}); end
    compared++; if (pma_cfg[3].a !== 2'b01) begin mismatched++; $display("FAIL cfg3_a_committed: got %b, expected 01", pma_cfg[3].a); end
    compared++; if ({pma_cfg[3].mem_type, pma_cfg[3].r, pma_cfg[3].w, pma_cfg[3].x, pma_cfg[3].m} !== 6'b011101) begin mismatched++; $display("FAIL cfg3_fields_committed: got %b, expected 011101", {pma_cfg[3].mem_type, pma_cfg[3].r, pma_cfg[3].w, pma_cfg[3].x, pma_cfg[3].m}); end
    cfg_if.req = 1'b0; drain_ack = 1'b0;
    @(posedge clk); #1;
    compared++; if ({cfg_if.ack, updated} !== 2'b00) begin mismatched++; $display("FAIL commit_pulse_width: got %b, expected 00", {cfg_if.ack, updated}); end
    access(1'b0, COMMIT, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL rd_commit_clean: got %h, expected 0", q); end
  endtask

  task automatic test_err_adr();
    logic [31:0] q; logic e, us, ds; int c;
    access(1'b0, 6'd33, 32'h0, q, e, c, us, ds);
    compared++; if ({c == 1, e, q} !== {1'b1, 1'b1, 32'h0}) begin mismatched++; $display("FAIL rd_idx33: got cyc=%0d err=%b q=%h, expected cyc=1 err=1 q=0", c, e, q); end
    access(1'b0, 6'd63, 32'h0, q, e, c, us, ds);
    compared++; if ({e, q} !== {1'b1, 32'h0}) begin mismatched++; $display("FAIL rd_idx63: got err=%b q=%h, expected err=1 q=0", e, q); end
    access(1'b1, 6'd5, 32'hFFFF_FFFF, q, e, c, us, ds);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL wr_adr2_err: got %b, expected 0", e); end
    access(1'b0, 6'd5, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL rd_adr2: got %h, expected ffffffff", q); end
    compared++; if (pma_adr[2] !== 32'h0) begin mismatched++; $display("FAIL adr2_active_early: got %h, expected 0", pma_adr[2]); end
  endtask

  task automatic test_warl();
    logic [31:0] q; logic e, us, ds; int c;
    logic [31:0] exp_q;
`ifdef PMA_LOCK_EN
    exp_q = 32'h0000_BFFF;
`else
    exp_q = 32'h0000_3FFF;
`endif
    access(1'b1, 6'd14, 32'hFFFF_FFFF, q, e, c, us, ds);
    access(1'b0, 6'd14, 32'h0, q, e, c, us, ds);
    compared++; if (q !== exp_q) begin mismatched++; $display("FAIL rd_cfg7_warl: got %h, expected %h", q, exp_q); end
  endtask

  task automatic test_commit_fast();
    logic [31:0] q; logic e, us, ds; int c;
    drain_ack = 1'b1;
    access(1'b1, COMMIT, 32'h0, q, e, c, us, ds);
    drain_ack = 1'b0;
    compared++; if (c !== 3) begin mismatched++; $display("FAIL fast_commit_latency: got %0d, expected 3", c); end
    compared++; if ({us, ds} !== 2'b11) begin mismatched++; $display("FAIL fast_commit_upd/drain: got %b, expected 11", {us, ds}); end
    compared++; if (pma_adr[2] !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL adr2_committed: got %h, expected ffffffff", pma_adr[2]); end
    compared++; if (pma_cfg[7].a !== NAPOT) begin mismatched++; $display("FAIL cfg7_committed: got %b, expected 11", pma_cfg[7].a); end
  endtask

  task automatic test_commit_clean();
    logic [31:0] q; logic e, us, ds; int c;
    access(1'b0, COMMIT, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL clean_rd_commit: got %h, expected 0", q); end
    access(1'b1, 6'd40, 32'h1234_5678, q, e, c, us, ds);
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL wr_idx40_err: got %b, expected 1", e); end
    access(1'b0, COMMIT, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL err_wr_dirty: got %h, expected 0", q); end
    access(1'b1, COMMIT, 32'h0, q, e, c, us, ds);
    compared++; if (c !== 1) begin mismatched++; $display("FAIL clean_commit_latency: got %0d, expected 1", c); end
    compared++; if ({us, ds} !== 2'b00) begin mismatched++; $display("FAIL clean_commit_upd/drain: got %b, expected 00", {us, ds}); end
    @(posedge clk); #1;
    compared++; if ({updated, drain_req, busy} !== 3'b000) begin mismatched++; $display("FAIL clean_commit_after: got %b, expected 000", {updated, drain_req, busy}); end
  endtask

  task automatic test_reset_midcommit();
    logic [31:0] q; logic e, us, ds; int c;
    access(1'b1, 6'd12, 32'h0000_00C1, q, e, c, us, ds);
    drain_ack = 1'b0;
    @(posedge clk); #1;
    cfg_if.req = 1'b1; cfg_if.we = 1'b1; cfg_if.adr = COMMIT;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL midcommit_busy: got %b, expected 1", busy); end
    rst_n = 1'b0; cfg_if.req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    compared++; if ({busy, drain_req, cfg_if.ack, updated} !== 4'b0000) begin mismatched++; $display("FAIL midreset_flags: got %b, expected 0000", {busy, drain_req, cfg_if.ack, updated}); end
    compared++; if ({pma_cfg[3], pma_cfg[6]} !== '0) begin mismatched++; $display("FAIL midreset_active: got %h %h, expected 0 0", pma_cfg[3], pma_cfg[6]); end
    compared++; if (pma_cfg[0].a !== NAPOT || pma_adr[2] !== 32'h0) begin mismatched++; $display("FAIL midreset_rst_vals: got a0=%b adr2=%h, expected 11 0", pma_cfg[0].a, pma_adr[2]); end
    access(1'b0, 6'd12, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL midreset_shadow6: got %h, expected 0", q); end
  endtask

`ifdef PMA_LOCK_EN
  task automatic test_lock();
    logic [31:0] q; logic e, us, ds; int c;
    access(1'b1, 6'd10, 32'h0000_8000 | 32'(TOR), q, e, c, us, ds);
    drain_ack = 1'b1;
    access(1'b1, COMMIT, 32'h0, q, e, c, us, ds);
    drain_ack = 1'b0;
    compared++; if (c !== 3 || pma_cfg[5].l !== 1'b1) begin mismatched++; $display("FAIL lock_commit: got cyc=%0d l=%b, expected 3 1", c, pma_cfg[5].l); end
    access(1'b1, 6'd9, 32'h1234_5678, q, e, c, us, ds);
    compared++; if ({c == 1, e} !== 2'b10) begin mismatched++; $display("FAIL locked_wr_ack: got cyc=%0d err=%b, expected 1 0", c, e); end
    access(1'b0, 6'd9, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL locked_adr4: got %h, expected 0", q); end
    access(1'b1, 6'd10, 32'h0, q, e, c, us, ds);
    access(1'b0, 6'd10, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0000_8002) begin mismatched++; $display("FAIL locked_cfg5: got %h, expected 00008002", q); end
    access(1'b0, COMMIT, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h0) begin mismatched++; $display("FAIL locked_dirty: got %h, expected 0", q); end
    apply_reset();
    access(1'b1, 6'd9, 32'h1234_5678, q, e, c, us, ds);
    access(1'b0, 6'd9, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h1234_5678) begin mismatched++; $display("FAIL unlocked_adr4: got %h, expected 12345678", q); end
    access(1'b0, COMMIT, 32'h0, q, e, c, us, ds);
    compared++; if (q !== 32'h2) begin mismatched++; $display("FAIL unlocked_dirty: got %h, expected 2", q); end
  endtask
`endif

  initial begin
    apply_reset();
    test_reset();
    test_rw_shadow();
    test_commit_drain();
    test_err_adr();
    test_warl();
    test_commit_fast();
    test_commit_clean();
    test_reset_midcommit();
`ifdef PMA_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
